// File: rtl/exception_port_select.sv
// Exception port select: redirects flagged packets to the CPU port paired with their source port.
// Optional build macro EXC_DROP_NONIP_EN drops packets whose only exception is non-IP.
module exception_port_select #(
    parameter int unsigned C_AXIS_DATA_WIDTH    = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH   = 128,
    parameter int unsigned SRC_PORT_POS         = 16,
    parameter int unsigned DST_PORT_POS         = 24,
    parameter int unsigned FLAG_FIFO_DEPTH_BITS = 2
) (
    input  logic                            AXI_ACLK,
    input  logic                            reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    input  logic                            S_AXIS_TLAST,
    input  logic [3:0]                      flags,
    input  logic                            flags_valid,
    output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic                            M_AXIS_TLAST,
    input  logic                            counter_clear,
    output logic [31:0]                     cpu_pkt_count,
    output logic [31:0]                     drop_count,
    output logic                            flag_overflow
);

    localparam int unsigned STRB_W   = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned BEAT_W   = C_AXIS_DATA_WIDTH + STRB_W + C_AXIS_TUSER_WIDTH + 1;
    localparam int unsigned DQ_DEPTH = 4;
    localparam int unsigned DQ_PTR_W = 2;
    localparam int unsigned DQ_CNT_W = 3;
    localparam int unsigned FQ_PTR_W = FLAG_FIFO_DEPTH_BITS;
    localparam int unsigned FQ_CNT_W = FLAG_FIFO_DEPTH_BITS + 1;
    localparam int unsigned FQ_DEPTH = 1 << FLAG_FIFO_DEPTH_BITS;

    typedef enum logic [1:0] {HDR, PASS, DROP} state_t;

    state_t state, state_next;

    // Data FIFO (fall-through): beat = {tdata, tstrb, tuser, tlast}
    logic [BEAT_W-1:0]   dq_mem [DQ_DEPTH];
    logic [DQ_PTR_W-1:0] dq_wr, dq_rd;
    logic [DQ_CNT_W-1:0] dq_count, dq_count_next;
    logic                dq_push, dq_pop, dq_empty;
    logic [BEAT_W-1:0]   head;

    logic [3:0]          fq_mem [FQ_DEPTH];
    logic [FQ_PTR_W-1:0] fq_wr, fq_rd;
    logic [FQ_CNT_W-1:0] fq_count;
    logic                fq_push, fq_pop, fq_empty, fq_full;
    logic [3:0]          fq_head;

    logic                          s_ready;
    logic [C_AXIS_DATA_WIDTH-1:0]  head_data;
    logic [STRB_W-1:0]             head_strb;
    logic [C_AXIS_TUSER_WIDTH-1:0] head_user, user_rw, out_user;
    logic                          head_last;
    logic [7:0]                    src;
    logic                          cpu_src, redirect, nonip_drop, drop_pkt;
    logic                          m_valid, inc_cpu, inc_drop;

    assign dq_push       = S_AXIS_TVALID & s_ready;
    assign dq_empty      = (dq_count == '0);
    assign dq_count_next = dq_count + DQ_CNT_W'(dq_push) - DQ_CNT_W'(dq_pop);
    assign head          = dq_mem[dq_rd];
    assign S_AXIS_TREADY = s_ready;

    always_ff @(posedge AXI_ACLK) begin
        if (dq_push) dq_mem[dq_wr] <= {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
    end

    // Ready is registered from the next occupancy so it equals !nearly_full every cycle
    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            dq_wr    <= '0;
            dq_rd    <= '0;
            dq_count <= '0;
            s_ready  <= 1'b0;
        end else begin
            if (dq_push) dq_wr <= dq_wr + DQ_PTR_W'(1);
            if (dq_pop)  dq_rd <= dq_rd + DQ_PTR_W'(1);
            dq_count <= dq_count_next;
            s_ready  <= (dq_count_next < DQ_CNT_W'(DQ_DEPTH - 1));
        end
    end

    assign fq_full  = (fq_count == FQ_CNT_W'(FQ_DEPTH));
    assign fq_empty = (fq_count == '0);
    assign fq_push  = flags_valid & ~fq_full;
    assign fq_head  = fq_mem[fq_rd];

    always_ff @(posedge AXI_ACLK) begin
        if (fq_push) fq_mem[fq_wr] <= flags;
    end

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            fq_wr         <= '0;
            fq_rd         <= '0;
            fq_count      <= '0;
            flag_overflow <= 1'b0;
        end else begin
            if (fq_push) fq_wr <= fq_wr + FQ_PTR_W'(1);
            if (fq_pop)  fq_rd <= fq_rd + FQ_PTR_W'(1);
            fq_count <= fq_count + FQ_CNT_W'(fq_push) - FQ_CNT_W'(fq_pop);
            if (flags_valid && fq_full) flag_overflow <= 1'b1;
        end
    end

    assign head_last = head[0];
    assign head_user = head[1 +: C_AXIS_TUSER_WIDTH];
    assign head_strb = head[1 + C_AXIS_TUSER_WIDTH +: STRB_W];
    assign head_data = head[1 + C_AXIS_TUSER_WIDTH + STRB_W +: C_AXIS_DATA_WIDTH];

    assign src      = head_user[SRC_PORT_POS +: 8];
    assign cpu_src  = |(src & 8'hAA);
    assign redirect = |fq_head;
`ifdef EXC_DROP_NONIP_EN
    assign nonip_drop = (fq_head == 4'b0100);
`else
    assign nonip_drop = 1'b0;
`endif
    assign drop_pkt = nonip_drop | (redirect & cpu_src);

    // MAC port k (bit 2k) maps to CPU port bit 2k+1
    always_comb begin
        user_rw = head_user;
        user_rw[DST_PORT_POS +: 8] = cpu_src ? 8'h00 : {src[6:0], 1'b0};
    end

    always_ff @(posedge AXI_ACLK) begin
        if (reset) state <= HDR;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        dq_pop     = 1'b0;
        fq_pop     = 1'b0;
        m_valid    = 1'b0;
        out_user   = head_user;
        inc_cpu    = 1'b0;
        inc_drop   = 1'b0;
        case (state)
            HDR: begin
                if (!dq_empty && !fq_empty) begin
                    if (drop_pkt) begin
                        // Dropped header is discarded without presenting it downstream
                        dq_pop   = 1'b1;
                        fq_pop   = 1'b1;
                        inc_drop = 1'b1;
                        if (!head_last) state_next = DROP;
                    end else begin
                        m_valid = 1'b1;
                        if (redirect) out_user = user_rw;
                        if (M_AXIS_TREADY) begin
                            dq_pop  = 1'b1;
                            fq_pop  = 1'b1;
                            inc_cpu = redirect;
                            if (!head_last) state_next = PASS;
                        end
                    end
                end
            end
            PASS: begin
                m_valid = !dq_empty;
                if (!dq_empty && M_AXIS_TREADY) begin
                    dq_pop = 1'b1;
                    if (head_last) state_next = HDR;
                end
            end
            DROP: begin
                if (!dq_empty) begin
                    dq_pop = 1'b1;
                    if (head_last) state_next = HDR;
                end
            end
            default: state_next = HDR;
        endcase
    end

    assign M_AXIS_TDATA  = head_data;
    assign M_AXIS_TSTRB  = head_strb;
    assign M_AXIS_TUSER  = out_user;
    assign M_AXIS_TLAST  = head_last;
    assign M_AXIS_TVALID = m_valid;

    // Clear wins over a same-cycle increment
    always_ff @(posedge AXI_ACLK) begin
        if (reset || counter_clear) begin
            cpu_pkt_count <= '0;
            drop_count    <= '0;
        end else begin
            if (inc_cpu)  cpu_pkt_count <= cpu_pkt_count + 32'd1;
            if (inc_drop) drop_count    <= drop_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_exception_port_select.sv
// Directed self-checking bench for exception_port_select (default 256/128-bit configuration).
module tb_exception_port_select;

    localparam int unsigned BW = 417;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] s_tdata;
    logic [31:0]  s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid, s_tready, s_tlast;
    logic [3:0]   flags;
    logic         flags_valid;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid, m_tready, m_tlast;
    logic         counter_clear;
    logic [31:0]  cpu_pkt_count, drop_count;
    logic         flag_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cpu  = 0;
    int exp_drop = 0;
    logic [BW-1:0] got_q[$];

    exception_port_select dut (
        .AXI_ACLK(clk), .reset(reset),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TLAST(s_tlast),
        .flags(flags), .flags_valid(flags_valid),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
        .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(m_tlast),
        .counter_clear(counter_clear), .cpu_pkt_count(cpu_pkt_count),
        .drop_count(drop_count), .flag_overflow(flag_overflow)
    );

    always #5 clk = ~clk;

    // Record every accepted output beat, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset && m_tvalid && m_tready)
            got_q.push_back({m_tdata, m_tstrb, m_tuser, m_tlast});
    end

    function automatic logic [BW-1:0] beat(input logic [31:0] tag, input logic [7:0] src,
                                           input logic [7:0] dst, input logic last);
        return {{8{tag}}, tag, {3{tag}}, dst, src, 16'hBEEF, last};
    endfunction

    task automatic send_beat(input logic [BW-1:0] b);
        bit acc;
        int n;
        {s_tdata, s_tstrb, s_tuser, s_tlast} = b;
        s_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        s_tvalid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: tready never seen, got %0b required 1", acc);
        end
    endtask

    task automatic strobe_flags(input logic [3:0] f);
        flags = f;
        flags_valid = 1'b1;
        @(posedge clk);
        #1;
        flags_valid = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        n_checks++;
        if (cpu_pkt_count !== 32'(exp_cpu)) begin
            n_fail++;
            $display("FAIL %s cpu_pkt_count: got %0d required %0d", tag, cpu_pkt_count, exp_cpu);
        end
        n_checks++;
        if (drop_count !== 32'(exp_drop)) begin
            n_fail++;
            $display("FAIL %s drop_count: got %0d required %0d", tag, drop_count, exp_drop);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({s_tready, m_tvalid, flag_overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 000", {s_tready, m_tvalid, flag_overflow});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b required 1", s_tready);
        end
        check_counters("reset");
        @(posedge clk);
        #1;
    endtask

    task automatic test_clean();
        logic [BW-1:0] exp [3];
        for (int i = 0; i < 3; i++) exp[i] = beat(32'h10 + 32'(i), 8'h01, 8'h04, i == 2);
        got_q.delete();
        strobe_flags(4'b0000);
        for (int i = 0; i < 3; i++) send_beat(exp[i]);
        run_cycles(8);
        n_checks++;
        if (got_q.size() != 3) begin
            n_fail++;
            $display("FAIL clean_count: got %0d beats required 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_q[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL clean_beat%0d: got %h required %h", i, got_q[i], exp[i]);
                end
            end
        end
        check_counters("clean");
    endtask

    task automatic test_ttl_redirect();
        logic [BW-1:0] in [3];
        logic [BW-1:0] exp [3];
        for (int i = 0; i < 3; i++) begin
            in[i]  = beat(32'h20 + 32'(i), 8'h04, 8'h10, i == 2);
            exp[i] = in[i];
        end
        exp[0] = beat(32'h20, 8'h04, 8'h08, 1'b0);
        got_q.delete();
        strobe_flags(4'b0001);
        for (int i = 0; i < 3; i++) send_beat(in[i]);
        run_cycles(8);
        exp_cpu++;
        n_checks++;
        if (got_q.size() != 3) begin
            n_fail++;
            $display("FAIL ttl_count: got %0d beats required 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_q[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL ttl_beat%0d: got %h required %h", i, got_q[i], exp[i]);
                end
            end
        end
        check_counters("ttl");
    endtask

    task automatic test_cpu_source_drop();
        logic [BW-1:0] exp [2];
        got_q.delete();
        strobe_flags(4'b1000);
        send_beat(beat(32'h30, 8'h02, 8'h01, 1'b0));
        send_beat(beat(32'h31, 8'h02, 8'h01, 1'b1));
        run_cycles(6);
        exp_drop++;
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL cpu_src_no_output: got %0d beats required 0", got_q.size());
        end
        check_counters("cpu_src");
        exp[0] = beat(32'h38, 8'h10, 8'h01, 1'b0);
        exp[1] = beat(32'h39, 8'h10, 8'h01, 1'b1);
        strobe_flags(4'b0000);
        send_beat(exp[0]);
        send_beat(exp[1]);
        run_cycles(6);
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL after_drop_count: got %0d beats required 2", got_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (got_q[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL after_drop_beat%0d: got %h required %h", i, got_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] in [7];
        logic [BW-1:0] exp [7];
        in[0] = beat(32'h40, 8'h01, 8'h80, 1'b0);
        in[1] = beat(32'h41, 8'h01, 8'h80, 1'b1);
        in[2] = beat(32'h48, 8'h40, 8'h01, 1'b0);
        in[3] = beat(32'h49, 8'h40, 8'h01, 1'b1);
        in[4] = beat(32'h50, 8'h10, 8'h04, 1'b0);
        in[5] = beat(32'h51, 8'h10, 8'h04, 1'b0);
        in[6] = beat(32'h52, 8'h10, 8'h04, 1'b1);
        exp = in;
        exp[0] = beat(32'h40, 8'h01, 8'h02, 1'b0);
        exp[4] = beat(32'h50, 8'h10, 8'h20, 1'b0);
        got_q.delete();
        strobe_flags(4'b0001);
        strobe_flags(4'b0000);
        strobe_flags(4'b0010);
        fork
            begin
                for (int i = 0; i < 7; i++) send_beat(in[i]);
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    m_tready = ~m_tready;
                end
            end
        join
        m_tready = 1'b1;
        run_cycles(10);
        exp_cpu += 2;
        n_checks++;
        if (got_q.size() != 7) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d beats required 7", got_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (got_q[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: got %h required %h", i, got_q[i], exp[i]);
                end
            end
        end
        check_counters("b2b");
    endtask

    task automatic test_single_overflow();
        logic [BW-1:0] exp;
        got_q.delete();
        strobe_flags(4'b0100);
        send_beat(beat(32'h60, 8'h10, 8'h01, 1'b1));
        run_cycles(5);
`ifdef EXC_DROP_NONIP_EN
        exp_drop++;
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL nonip_drop_count: got %0d beats required 0", got_q.size());
        end
`else
        exp = beat(32'h60, 8'h10, 8'h20, 1'b1);
        exp_cpu++;
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d beats required 1", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0] !== exp) begin
                n_fail++;
                $display("FAIL single_beat: got %h required %h", got_q[0], exp);
            end
        end
`endif
        check_counters("single");
        for (int i = 0; i < 4; i++) strobe_flags(4'b0000);
        n_checks++;
        if (flag_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_early: got %b required 0", flag_overflow);
        end
        strobe_flags(4'b0000);
        n_checks++;
        if (flag_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got %b required 1", flag_overflow);
        end
    endtask

    task automatic test_reset_clear();
        logic [BW-1:0] exp [2];
        // Leave the stage mid-packet (in PASS) using one of the queued zero flag entries
        send_beat(beat(32'h70, 8'h01, 8'h04, 1'b0));
        send_beat(beat(32'h71, 8'h01, 8'h04, 1'b0));
        run_cycles(3);
        reset = 1'b1;
        run_cycles(2);
        n_checks++;
        if (s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b required 0", s_tready);
        end
        reset = 1'b0;
        run_cycles(2);
        got_q.delete();
        exp_cpu = 0;
        exp_drop = 0;
        n_checks++;
        if ({m_tvalid, flag_overflow, s_tready} !== 3'b001) begin
            n_fail++;
            $display("FAIL midreset_state: got %b required 001", {m_tvalid, flag_overflow, s_tready});
        end
        check_counters("midreset");
        exp[0] = beat(32'h80, 8'h04, 8'h08, 1'b0);
        exp[1] = beat(32'h81, 8'h04, 8'h01, 1'b1);
        strobe_flags(4'b0001);
        send_beat(beat(32'h80, 8'h04, 8'h01, 1'b0));
        send_beat(exp[1]);
        run_cycles(6);
        exp_cpu++;
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL postreset_count: got %0d beats required 2", got_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (got_q[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL postreset_beat%0d: got %h required %h", i, got_q[i], exp[i]);
                end
            end
        end
        check_counters("postreset");
        got_q.delete();
        m_tready = 1'b0;
        strobe_flags(4'b0001);
        send_beat(beat(32'h90, 8'h01, 8'h04, 1'b1));
        run_cycles(2);
        n_checks++;
        if (m_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_pending_valid: got %b required 1", m_tvalid);
        end
        m_tready = 1'b1;
        counter_clear = 1'b1;
        @(posedge clk);
        #1;
        counter_clear = 1'b0;
        run_cycles(2);
        exp_cpu = 0;
        check_counters("clear");
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++;
            $display("FAIL clear_beat_count: got %0d beats required 1", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0] !== beat(32'h90, 8'h01, 8'h02, 1'b1)) begin
                n_fail++;
                $display("FAIL clear_beat: got %h required %h", got_q[0], beat(32'h90, 8'h01, 8'h02, 1'b1));
            end
        end
    endtask

    initial begin
        s_tdata = '0;
        s_tstrb = '0;
        s_tuser = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        flags = '0;
        flags_valid = 1'b0;
        m_tready = 1'b1;
        counter_clear = 1'b0;
        test_reset();
        test_clean();
        test_ttl_redirect();
        test_cpu_source_drop();
        test_back_to_back();
        test_single_overflow();
        test_reset_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
